program_loader: RTL and testbench

//  Upstream of the 4-bit CPU's program-mode RAM port; replaces hand-driven data/addr/We1 sequencing.
//  - Accepts a byte stream over a valid/ready handshake.
//  - Writes DEPTH program bytes to RAM, then verifies a trailing checksum byte.
//  - On a good checksum, selects RUN mode (a=1) and releases the CPU reset after a hold time.

---
 rtl/program_loader_pkg.sv | 17 +
 rtl/program_loader.sv | 113 +++++++++++
 tb/tb_program_loader.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared loader definitions: state encodings, bus width defaults
// and CPU mode-select values.
package program_loader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] ST_LOAD  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_ERROR = 3'd4;

    localparam logic MODE_PROGRAM = 1'b0;
    localparam logic MODE_RUN     = 1'b1;

endpackage

// File: rtl/program_loader.sv
// Streams a program image into CPU RAM, verifies its checksum,
// then switches the CPU to RUN and releases its reset.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DEPTH      = 2 ** ADDR_W,
    parameter int RESET_HOLD = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              restart,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] addr,
    output logic              We1,
    output logic              a,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int TW = $clog2(RESET_HOLD + 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;
    logic [TW-1:0]     timer;
    logic              xfer;

    assign xfer     = in_valid & in_ready;
    assign sum_next = sum + in_data;

    always_ff @(posedge Clock) begin
        if (Reset || restart) begin
            state     <= ST_LOAD;
            count     <= '0;
            sum       <= '0;
            timer     <= '0;
            data      <= '0;
            addr      <= '0;
            We1       <= 1'b0;
            a         <= MODE_PROGRAM;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            // restart alone reopens the stream on the very next cycle
            in_ready  <= !Reset;
        end else begin
            We1 <= 1'b0;
            unique case (state)
                ST_LOAD: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        data <= in_data;
                        addr <= count;
                        We1  <= 1'b1;
                        sum  <= sum_next;
                        if (count == ADDR_W'(DEPTH - 1)) begin
                            count <= '0;
                            state <= ST_CHECK;
                        end else begin
                            count <= count + ADDR_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    in_ready <= 1'b1;
                    if (xfer) begin
                        in_ready <= 1'b0;
                        if (sum_next == '0) begin
                            state <= ST_HOLD;
                            a     <= MODE_RUN;
                            timer <= TW'(RESET_HOLD);
                        end else begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    in_ready <= 1'b0;
                    if (timer == TW'(1)) begin
                        timer     <= '0;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_RUN;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                ST_RUN: begin
                    in_ready <= 1'b0;
                end
                ST_ERROR: begin
                    in_ready  <= 1'b0;
                    a         <= MODE_PROGRAM;
                    cpu_reset <= 1'b1;
                    error     <= 1'b1;
                end
                default: begin
                    state    <= ST_LOAD;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scenario table, timing
// sequences and randomized images against a stream-level model.
module tb_program_loader;

    typedef logic [7:0] img_t [16];

    typedef struct {
        logic [7:0] csum;
        int         gap;
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       restart = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] data;
    logic [3:0] addr;
    logic       We1;
    logic       a;
    logic       cpu_reset;
    logic       done;
    logic       error;

    program_loader #(
        .DATA_W(8), .ADDR_W(4), .DEPTH(16), .RESET_HOLD(2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .restart(restart),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data(data), .addr(addr), .We1(We1), .a(a),
        .cpu_reset(cpu_reset), .done(done), .error(error)
    );

    always #5 Clock = ~Clock;

    logic [7:0] ram [16];
    int         cyc = 0;
    int         wr_cyc [$];
    int         wr_addr [$];
    logic [7:0] wr_data [$];

    // RAM stand-in: samples the write port on each rising edge
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (We1) begin
            ram[addr] <= data;
            wr_cyc.push_back(cyc);
            wr_addr.push_back(int'(addr));
            wr_data.push_back(data);
        end
    end

    int ncmp = 0;
    int nfail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        restart = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        Reset = 1'b0;
        step();
        clear_log();
    endtask

    task automatic pulse_restart(input logic [7:0] junk);
        restart = 1'b1;
        in_valid = 1'b1;
        in_data = junk;
        step();
        restart = 1'b0;
        in_valid = 1'b0;
    endtask

    // gap: 0 none, 1 one idle cycle per byte, 2 random 0..2
    task automatic send(input logic [7:0] b, input int gap);
        int g;
        int n;
        g = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            in_data = 8'($urandom);
            step();
        end
        in_valid = 1'b1;
        in_data = b;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        step();
    endtask

    task automatic send_image(input img_t im, input logic [7:0] cs,
                              input int gap);
        for (int i = 0; i < 16; i++) send(im[i], gap);
        send(cs, gap);
        in_valid = 1'b0;
    endtask

    task automatic wait_outcome();
        int n;
        n = 0;
        while (!done && !error && n < 10) begin
            step();
            n++;
        end
        chk("outcome_timeout", 32'(n < 10), 32'd1);
    endtask

    function automatic int ram_diff(input img_t ex);
        int d;
        d = 0;
        for (int i = 0; i < 16; i++) if (ram[i] !== ex[i]) d++;
        return d;
    endfunction

    function automatic int log_diff(input img_t ex);
        int d;
        d = 0;
        for (int i = 0; i < wr_addr.size() && i < 16; i++)
            if (wr_addr[i] != i || wr_data[i] !== ex[i]) d++;
        return d;
    endfunction

    // Reference: image accepted iff all 17 bytes sum to 0 mod 256
    function automatic logic model_ok(input img_t im, input logic [7:0] cs);
        int s;
        s = int'(cs);
        for (int i = 0; i < 16; i++) s += int'(im[i]);
        return (s % 256) == 0;
    endfunction

    img_t fib;
    img_t rim;
    img_t junk;
    vec_t vt [4];
    logic [7:0] rs;
    logic [7:0] rcs;
    logic rgood;
    int k;
    int nw;

    initial begin
        fib = '{8'hBF, 8'h0E, 8'hE0, 8'hBD, 8'h8D, 8'hBF, 8'h0E, 8'hE0,
                8'hBD, 8'h8F, 8'hBE, 8'hAC, 8'h04, 8'h00, 8'h01, 8'h01};
        vt[0] = '{8'hA0, 0, 1'b1, 1'b0};
        vt[1] = '{8'hA1, 0, 1'b0, 1'b1};
        vt[2] = '{8'hA0, 1, 1'b1, 1'b0};
        vt[3] = '{8'h5F, 1, 1'b0, 1'b1};
        for (int i = 0; i < 16; i++) ram[i] = '0;

        // reset state
        step();
        step();
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_we1", 32'(We1), 32'd0);
        chk("rst_a", 32'(a), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        Reset = 1'b0;
        step();
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // scenario table: good/bad checksum, with and without stalls
        for (int v = 0; v < 4; v++) begin
            do_reset();
            for (int i = 0; i < 16; i++) ram[i] = 8'hEE;
            send_image(fib, vt[v].csum, vt[v].gap);
            wait_outcome();
            step();
            chk("tbl_done", 32'(done), 32'(vt[v].exp_done));
            chk("tbl_error", 32'(error), 32'(vt[v].exp_err));
            chk("tbl_a", 32'(a), 32'(vt[v].exp_done));
            chk("tbl_cpu_reset", 32'(cpu_reset), 32'(!vt[v].exp_done));
            chk("tbl_in_ready", 32'(in_ready), 32'd0);
            chk("tbl_nwrites", 32'(wr_addr.size()), 32'd16);
            chk("tbl_ram", 32'(ram_diff(fib)), 32'd0);
            chk("tbl_log", 32'(log_diff(fib)), 32'd0);
            if (vt[v].gap == 0)
                chk("tbl_b2b", 32'(wr_cyc[15] - wr_cyc[0]), 32'd15);
        end

        // T2 tail: bytes after an error are refused
        nw = wr_addr.size();
        in_valid = 1'b1;
        in_data = 8'h12;
        step();
        step();
        step();
        chk("err_ready", 32'(in_ready), 32'd0);
        chk("err_nowrite", 32'(wr_addr.size()), 32'(nw));
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_a", 32'(a), 32'd0);
        in_valid = 1'b0;

        // T1 hold timing
        do_reset();
        send_image(fib, 8'hA0, 0);
        chk("hold0_a", 32'(a), 32'd1);
        chk("hold0_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("hold0_done", 32'(done), 32'd0);
        chk("hold0_we1", 32'(We1), 32'd0);
        step();
        chk("hold1_a", 32'(a), 32'd1);
        chk("hold1_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        chk("run_a", 32'(a), 32'd1);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("run_done", 32'(done), 32'd1);
        in_valid = 1'b1;
        in_data = 8'h33;
        step();
        step();
        chk("run_ignores", 32'(wr_addr.size()), 32'd16);
        in_valid = 1'b0;

        // T4 restart at count=7
        do_reset();
        for (int i = 0; i < 7; i++) send(fib[i], 0);
        pulse_restart(8'h99);
        chk("rs_we1", 32'(We1), 32'd0);
        chk("rs_in_ready", 32'(in_ready), 32'd1);
        chk("rs_addr", 32'(addr), 32'd0);
        step();
        chk("rs_partial_n", 32'(wr_addr.size()), 32'd7);
        clear_log();
        send_image(fib, 8'hA0, 0);
        wait_outcome();
        chk("rs_first_addr", 32'(wr_addr[0]), 32'd0);
        chk("rs_nwrites", 32'(wr_addr.size()), 32'd16);
        chk("rs_ram", 32'(ram_diff(fib)), 32'd0);
        chk("rs_done", 32'(done), 32'd1);

        // T5 Reset in HOLD, then in RUN
        do_reset();
        send_image(fib, 8'hA0, 0);
        Reset = 1'b1;
        step();
        chk("rh_a", 32'(a), 32'd0);
        chk("rh_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rh_done", 32'(done), 32'd0);
        chk("rh_we1", 32'(We1), 32'd0);
        Reset = 1'b0;
        step();
        chk("rh_ready", 32'(in_ready), 32'd1);
        send_image(fib, 8'hA0, 0);
        wait_outcome();
        Reset = 1'b1;
        step();
        chk("rr_a", 32'(a), 32'd0);
        chk("rr_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rr_done", 32'(done), 32'd0);
        Reset = 1'b0;
        step();
        chk("rr_ready", 32'(in_ready), 32'd1);

        // T6 Reset+restart with a valid byte, then restart alone
        clear_log();
        for (int i = 0; i < 3; i++) send(fib[i], 0);
        Reset = 1'b1;
        restart = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h55;
        step();
        Reset = 1'b0;
        restart = 1'b0;
        in_valid = 1'b0;
        chk("rb_in_ready", 32'(in_ready), 32'd0);
        chk("rb_we1", 32'(We1), 32'd0);
        step();
        chk("rb_nwrites", 32'(wr_addr.size()), 32'd3);
        for (int i = 0; i < 3; i++) send(fib[i], 0);
        pulse_restart(8'h77);
        step();
        clear_log();
        send_image(fib, 8'hA0, 0);
        wait_outcome();
        chk("rb_sum_cleared", 32'(done), 32'd1);
        chk("rb_ram", 32'(ram_diff(fib)), 32'd0);

        // randomized images against the stream-level model
        for (int it = 0; it < 24; it++) begin
            rs = '0;
            for (int i = 0; i < 16; i++) begin
                rim[i] = 8'($urandom);
                junk[i] = 8'($urandom);
                rs = rs + rim[i];
            end
            rgood = 1'($urandom_range(0, 1));
            rcs = 8'(-rs);
            if (!rgood) rcs = rcs + 8'($urandom_range(1, 255));
            if (it % 2 == 0) do_reset();
            else pulse_restart(8'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                k = int'($urandom_range(1, 15));
                for (int i = 0; i < k; i++) send(junk[i], 2);
                pulse_restart(8'($urandom));
            end
            clear_log();
            send_image(rim, rcs, 2);
            wait_outcome();
            chk("rnd_done", 32'(done), 32'(model_ok(rim, rcs)));
            chk("rnd_error", 32'(error), 32'(!model_ok(rim, rcs)));
            chk("rnd_nwrites", 32'(wr_addr.size()), 32'd16);
            chk("rnd_ram", 32'(ram_diff(rim)), 32'd0);
            chk("rnd_log", 32'(log_diff(rim)), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
